// File: rtl/turn_arbiter.sv
// turn_arbiter: grants the shared board-input channel to the player or the AI, one side per turn.
// Optional TURN_TIMEOUT_EN adds a per-turn forfeit timer and a one-cycle timeout output.
module turn_arbiter #(
    parameter int CELLS          = 9,
    parameter int IDX_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] player_loc,
    input  logic             player_submit,
    input  logic             player_reset,
    input  logic [IDX_W-1:0] ai_loc,
    input  logic             ai_submit,
    input  logic             ai_reset,
    input  logic [CELLS-1:0] board_occupied,
    input  logic             board_game_over,
    output logic [IDX_W-1:0] board_loc,
    output logic             board_submit,
    output logic             board_reset,
    output logic             turn,
    output logic [3:0]       move_count,
    output logic             reject,
`ifdef TURN_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             done
);
    typedef enum logic [2:0] {S_TURN, S_COMMIT, S_SETTLE, S_DONE, S_CLEAR} state_t;
    state_t           state_q, state_d;
    logic             turn_q, turn_d, rej_q, rej_d, p_sub_q, a_sub_q;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] loc_q, loc_d;
    logic             p_ev, a_ev, ev, rq, legal, over;
    logic [IDX_W-1:0] sel_loc;
`ifdef TURN_TIMEOUT_EN
    logic [15:0]      to_q, to_d;
    logic             tmo_q, tmo_d;
`endif
    assign p_ev    = player_submit & ~p_sub_q;
    assign a_ev    = ai_submit & ~a_sub_q;
    assign ev      = turn_q ? a_ev : p_ev;
    assign rq      = turn_q ? ai_reset : player_reset;
    assign sel_loc = turn_q ? ai_loc : player_loc;
    assign legal   = (int'(sel_loc) < CELLS) && !board_occupied[sel_loc];
    assign over    = board_game_over || (cnt_q == 4'(CELLS));
    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        cnt_d   = cnt_q;
        loc_d   = loc_q;
        rej_d   = 1'b0;
        case (state_q)
            S_TURN: begin
                if (ev && rq) state_d = S_CLEAR;
                else if (ev && legal) begin
                    loc_d   = sel_loc;
                    state_d = S_COMMIT;
                end else rej_d = ev;
            end
            S_COMMIT: begin
                cnt_d   = (cnt_q == 4'(CELLS)) ? cnt_q : cnt_q + 4'd1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = over ? S_DONE : S_TURN;
                turn_d  = over ? turn_q : ~turn_q;
            end
            S_DONE:  state_d = ((p_ev && player_reset) || (a_ev && ai_reset)) ? S_CLEAR : S_DONE;
            default: state_d = S_TURN;
        endcase
        // game state is wiped on entry so the clear pulse already shows a fresh game
        if (state_d == S_CLEAR) begin
            cnt_d  = '0;
            turn_d = 1'b0;
            loc_d  = '0;
        end
`ifdef TURN_TIMEOUT_EN
        to_d  = (state_q == S_TURN) ? to_q + 16'd1 : 16'd0;
        tmo_d = 1'b0;
        if (state_q == S_TURN && state_d == S_TURN && to_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_DONE;
            tmo_d   = 1'b1;
        end
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_TURN;
            turn_q  <= 1'b0;
            cnt_q   <= '0;
            loc_q   <= '0;
            rej_q   <= 1'b0;
            p_sub_q <= 1'b0;
            a_sub_q <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            to_q    <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            cnt_q   <= cnt_d;
            loc_q   <= loc_d;
            rej_q   <= rej_d;
            p_sub_q <= player_submit;
            a_sub_q <= ai_submit;
`ifdef TURN_TIMEOUT_EN
            to_q    <= to_d;
            tmo_q   <= tmo_d;
`endif
        end
    end
    assign board_loc    = loc_q;
    assign board_submit = state_q == S_COMMIT;
    assign board_reset  = state_q == S_CLEAR;
    assign done         = state_q == S_DONE;
    assign turn         = turn_q;
    assign move_count   = cnt_q;
    assign reject       = rej_q;
`ifdef TURN_TIMEOUT_EN
    assign timeout      = tmo_q;
`endif
endmodule

// File: doc/turn_arbiter.md
Name: turn_arbiter

Overview:
- Owns the shared board-input channel (location, submit, reset) and grants it to the player or the AI source, one side per turn.
- Replaces tri-state sharing with a registered mux. Validates each move against board occupancy, pulses the commit into the board, then samples the board's game-over flag.
- Tracks turn and move count, ends the game on a win or a full board, and sequences game reset.
- Sits between the player/AI generators and the board.

Parameters:
- CELLS, 9, number of board cells; legal indices are 0..CELLS-1.
- IDX_W, 4, width of location buses; must satisfy 2^IDX_W >= CELLS.
- TIMEOUT_CYCLES, 1024, turn timeout in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- player_loc  in  IDX_W  player's requested cell.
- player_submit  in  1  player strobe, edge-detected.
- player_reset  in  1  player's game-reset qualifier, sampled on the submit edge.
- ai_loc  in  IDX_W  AI's requested cell.
- ai_submit  in  1  AI strobe, edge-detected.
- ai_reset  in  1  AI's game-reset qualifier.
- board_occupied  in  CELLS  bit i = 1 when cell i is taken.
- board_game_over  in  1  board's win-detect flag.
- board_loc  out  IDX_W  committed cell index to the board.
- board_submit  out  1  one-cycle commit pulse to the board.
- board_reset  out  1  one-cycle clear pulse to the board.
- turn  out  1  0 = player's turn (TURN_PLAYER), 1 = AI's turn.
- move_count  out  4  moves committed in the current game.
- reject  out  1  one-cycle pulse when an illegal move is refused.
- done  out  1  high while the game is over.

Behaviour:
- Reset (rst_n low, async): state=S_TURN, turn=0, move_count=0, board_loc=0. board_submit, board_reset, reject, done and the submit edge registers all 0.
- Edge detect: each submit input is registered. An event is a 0->1 transition seen on a clock edge. Level-high holding never repeats an event.
- Only the side named by turn is sampled. Events from the other side are dropped silently.
- S_TURN, event with qualifier reset=1:
  - go to S_CLEAR.
- S_TURN, event with reset=0 and loc < CELLS and board_occupied[loc] = 0:
  - latch loc into board_loc;
  - go to S_COMMIT.
- S_TURN, event with reset=0 and (loc >= CELLS or cell occupied):
  - reject=1 for one cycle;
  - stay in S_TURN; turn and count are unchanged.
- S_COMMIT (1 cycle):
  - board_submit=1;
  - move_count increments (saturates at CELLS);
  - go to S_SETTLE.
- S_SETTLE (1 cycle), sampling board_game_over:
  - if it is 1 or move_count == CELLS: go to S_DONE and set done=1; turn is not toggled.
  - otherwise: toggle turn and go to S_TURN.
- Latency: edge at cycle N, then board_submit at N+1, then new turn at N+3.
- S_DONE:
  - accepts a reset-qualified event from either side;
  - events without the reset qualifier are ignored (no reject);
  - if both sides raise reset events in the same cycle, player priority applies (one clear only).
- S_CLEAR (1 cycle):
  - board_reset=1, move_count=0, turn=0, done=0, board_loc=0;
  - go to S_TURN.
- Events arriving in S_COMMIT, S_SETTLE or S_CLEAR are discarded, not queued. A reset request during a commit is therefore lost and must be re-issued.
- Edge registers keep tracking in every state, so a strobe held across a busy state does not fire later.
- Async reset mid-sequence aborts immediately to reset values. A board_submit pulse in progress is cut short.

Optional Feature:
- Macro TURN_TIMEOUT_EN.
- When defined:
  - a 16-bit counter clears on every entry to S_TURN and counts while in S_TURN;
  - at TIMEOUT_CYCLES-1 without an accepted move, the side to move forfeits: go to S_DONE with done=1, and a timeout output pulses for one cycle;
  - turn holds the forfeiting side;
  - rejected moves do not clear the counter.
- When undefined: no counter, no timeout port, and S_TURN waits indefinitely.

Test Plan:
- Player submits loc=0 on an empty board, then releases:
  - board_submit pulses at N+1 with board_loc=0;
  - move_count becomes 1 and turn becomes 1 at N+3.
- AI's turn; player submit pulses with loc=4:
  - no board_submit, no reject, turn stays 1.
- Player's turn with cell 2 occupied; player submits loc=2, then loc=11:
  - reject pulses twice, move_count unchanged, turn stays 0.
- Alternate 9 legal moves with board_game_over held at 0:
  - done=1 after the 9th S_SETTLE and move_count=9;
  - a further submit without reset is ignored.
- Drive board_game_over=1 during S_SETTLE of move 5, then player submit with player_reset=1:
  - done=1; then one board_reset pulse, move_count=0, turn=0, done=0.
- Assert rst_n low mid-S_COMMIT:
  - all outputs return to reset values asynchronously;
  - with TURN_TIMEOUT_EN and TIMEOUT_CYCLES=16, idle 16 cycles -> timeout pulse and done=1.
